// File: rtl/imm_gen_pkg.sv
// -----------------------------------------------------------------------------
// imm_gen_pkg
//
// Shared definitions for the pipelined immediate generator:
//   imm_type_e   - encoding of the IMMEDIATE_TYPE select input
//   buf_state_e  - occupancy state of the two-entry elastic output buffer
// -----------------------------------------------------------------------------
package imm_gen_pkg;

    // Immediate format select. The encodings are part of the block interface,
    // so every value is pinned explicitly rather than left to enum numbering.
    typedef enum logic [2:0] {
        IMM_I     = 3'b000,
        IMM_S     = 3'b001,
        IMM_J     = 3'b010,
        IMM_U     = 3'b011,
        IMM_B     = 3'b100,
        IMM_SHAMT = 3'b101,
        IMM_ZIMM  = 3'b110,
        IMM_BAD   = 3'b111
    } imm_type_e;

    // Elastic buffer occupancy: number of decoded results currently held.
    typedef enum logic [1:0] {
        EMPTY = 2'b00,
        ONE   = 2'b01,
        FULL  = 2'b10
    } buf_state_e;

endpackage : imm_gen_pkg

// File: rtl/imm_decode.sv
// -----------------------------------------------------------------------------
// imm_decode
//
// Purely combinational immediate extraction for one 32-bit instruction word.
//
// Parameters
//   XLEN        - width of the produced immediate (32 or 64)
//
// Ports
//   instr_i     - raw instruction word
//   imm_type_i  - immediate format select
//   imm_o       - decoded immediate, extended to XLEN bits
//   illegal_o   - high when imm_type_i selects the unsupported encoding
// -----------------------------------------------------------------------------
module imm_decode
    import imm_gen_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [31:0]     instr_i,
    input  imm_type_e       imm_type_i,
    output logic [XLEN-1:0] imm_o,
    output logic            illegal_o
);

    // 32-bit form of the immediate. Every format is built so that bit 31 is
    // already the correct fill bit: sign-extended formats replicate instr[31],
    // zero-extended formats (SHAMT, ZIMM, BAD) are small enough that bit 31 is 0.
    // Widening to 64 bits is therefore a plain replication of raw32[31].
    logic [31:0] raw32;

    // The opcode field never contributes to any immediate format.
    logic unused_opcode;
    assign unused_opcode = ^instr_i[6:0];

    // NOTE: every output of a combinational block gets a default before the
    // case statement, so no path through it can leave a value unassigned and
    // infer a latch.
    always_comb begin
        raw32     = '0;
        illegal_o = 1'b0;
        case (imm_type_i)
            IMM_I: raw32 = {{20{instr_i[31]}}, instr_i[31:20]};
            IMM_S: raw32 = {{20{instr_i[31]}}, instr_i[31:25], instr_i[11:7]};
            IMM_J: raw32 = {{12{instr_i[31]}}, instr_i[19:12], instr_i[20],
                            instr_i[30:21], 1'b0};
            IMM_U: raw32 = {instr_i[31:12], 12'b0};
            IMM_B: raw32 = {{20{instr_i[31]}}, instr_i[7], instr_i[30:25],
                            instr_i[11:8], 1'b0};
            IMM_SHAMT: begin
                // RV64 shift amounts are 6 bits wide, RV32 shift amounts 5.
                if (XLEN == 64) begin
                    raw32 = {26'b0, instr_i[25:20]};
                end else begin
                    raw32 = {27'b0, instr_i[24:20]};
                end
            end
            IMM_ZIMM: raw32 = {27'b0, instr_i[19:15]};
            IMM_BAD: begin
                raw32     = '0;
                illegal_o = 1'b1;
            end
            default: begin
                raw32     = '0;
                illegal_o = 1'b0;
            end
        endcase
    end

    // Widen to XLEN. Only the branch matching the parameter is elaborated, so
    // both branches have exactly matching widths.
    generate
        if (XLEN == 64) begin : g_xlen64
            assign imm_o = {{32{raw32[31]}}, raw32};
        end else begin : g_xlen32
            assign imm_o = raw32;
        end
    endgenerate

endmodule : imm_decode

// File: rtl/imm_gen_pipelined.sv
// -----------------------------------------------------------------------------
// imm_gen_pipelined
//
// Immediate generator with a valid/ready interface on both sides. The
// instruction is decoded combinationally on the way in and the result (with
// its sideband tag and illegal flag) is captured in a two-entry elastic
// buffer. The second entry lets IN_READY come straight from a flop while
// still sustaining one instruction per cycle.
//
// Parameters
//   XLEN            - immediate width, 32 or 64
//   TAG_W           - width of the sideband tag
//
// Ports
//   CLK             - clock, all state updates on the rising edge
//   RESET_N         - asynchronous active-low reset
//   IN_VALID        - upstream offers an instruction
//   IN_READY        - block accepts an instruction this cycle (registered)
//   INSTRUCTION     - raw instruction word
//   IMMEDIATE_TYPE  - immediate format select (see imm_gen_pkg::imm_type_e)
//   IN_TAG          - sideband tag travelling with the instruction
//   OUT_VALID       - a decoded result is presented
//   OUT_READY       - downstream consumes the presented result
//   IMMEDIATE_VALUE - decoded immediate
//   OUT_TAG         - tag belonging to IMMEDIATE_VALUE
//   ILLEGAL_TYPE    - result came from the unsupported format select
// -----------------------------------------------------------------------------
module imm_gen_pipelined
    import imm_gen_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int TAG_W = 4
) (
    input  logic             CLK,
    input  logic             RESET_N,
    input  logic             IN_VALID,
    output logic             IN_READY,
    input  logic [31:0]      INSTRUCTION,
    input  logic [2:0]       IMMEDIATE_TYPE,
    input  logic [TAG_W-1:0] IN_TAG,
    output logic             OUT_VALID,
    input  logic             OUT_READY,
    output logic [XLEN-1:0]  IMMEDIATE_VALUE,
    output logic [TAG_W-1:0] OUT_TAG,
    output logic             ILLEGAL_TYPE
);

    // ---------------------------------------------------------------------
    // Decode ahead of the buffer
    // ---------------------------------------------------------------------
    logic [XLEN-1:0] dec_imm;
    logic            dec_illegal;

    imm_decode #(
        .XLEN (XLEN)
    ) u_imm_decode (
        .instr_i    (INSTRUCTION),
        .imm_type_i (imm_type_e'(IMMEDIATE_TYPE)),
        .imm_o      (dec_imm),
        .illegal_o  (dec_illegal)
    );

    // ---------------------------------------------------------------------
    // Buffer control
    // ---------------------------------------------------------------------
    buf_state_e state_q, state_d;
    logic       in_ready_q, in_ready_d;

    logic in_xfer;
    logic out_xfer;
    logic load_head;   // head entry captures the freshly decoded result
    logic load_skid;   // skid entry captures the freshly decoded result
    logic shift_skid;  // skid entry moves up into the head

    assign OUT_VALID = (state_q != EMPTY);
    assign IN_READY  = in_ready_q;
    assign in_xfer   = IN_VALID & in_ready_q;
    assign out_xfer  = OUT_VALID & OUT_READY;

    always_comb begin
        state_d    = state_q;
        load_head  = 1'b0;
        load_skid  = 1'b0;
        shift_skid = 1'b0;
        case (state_q)
            EMPTY: begin
                if (in_xfer) begin
                    state_d   = ONE;
                    load_head = 1'b1;
                end
            end
            ONE: begin
                case ({in_xfer, out_xfer})
                    2'b10: begin
                        // Head is stalled; park the new result behind it.
                        state_d   = FULL;
                        load_skid = 1'b1;
                    end
                    2'b01: state_d = EMPTY;
                    2'b11: begin
                        // Head leaves as the new result arrives: pass-through.
                        state_d   = ONE;
                        load_head = 1'b1;
                    end
                    default: state_d = ONE;
                endcase
            end
            FULL: begin
                // IN_READY is low in FULL, so no input transfer can occur here.
                if (out_xfer) begin
                    state_d    = ONE;
                    shift_skid = 1'b1;
                end
            end
            default: state_d = EMPTY;
        endcase
    end

    // IN_READY is a function of the next state only, so it is registered and
    // has no combinational dependence on OUT_READY.
    assign in_ready_d = (state_d != FULL);

    // NOTE: sequential state is updated with non-blocking assignments so every
    // flop samples the values from before the clock edge.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q    <= EMPTY;
            in_ready_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            in_ready_q <= in_ready_d;
        end
    end

    // ---------------------------------------------------------------------
    // Buffer storage
    // ---------------------------------------------------------------------
    logic [XLEN-1:0]  head_imm_q, skid_imm_q;
    logic [TAG_W-1:0] head_tag_q, skid_tag_q;
    logic             head_ill_q, skid_ill_q;

    // NOTE: the payload entries are reset as well as the state: the outputs
    // are driven straight from the head entry and must read zero in reset,
    // and with only two entries the reset cost is negligible.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            head_imm_q <= '0;
            head_tag_q <= '0;
            head_ill_q <= 1'b0;
            skid_imm_q <= '0;
            skid_tag_q <= '0;
            skid_ill_q <= 1'b0;
        end else begin
            if (load_head) begin
                head_imm_q <= dec_imm;
                head_tag_q <= IN_TAG;
                head_ill_q <= dec_illegal;
            end else if (shift_skid) begin
                head_imm_q <= skid_imm_q;
                head_tag_q <= skid_tag_q;
                head_ill_q <= skid_ill_q;
            end
            if (load_skid) begin
                skid_imm_q <= dec_imm;
                skid_tag_q <= IN_TAG;
                skid_ill_q <= dec_illegal;
            end
        end
    end

    // The head entry is always the oldest result, and it is held untouched
    // while OUT_READY is low, which keeps the outputs stable under stall.
    assign IMMEDIATE_VALUE = head_imm_q;
    assign OUT_TAG         = head_tag_q;
    assign ILLEGAL_TYPE    = head_ill_q;

endmodule : imm_gen_pipelined

// File: tb/tb_imm_gen_pipelined.sv
// -----------------------------------------------------------------------------
// tb_imm_gen_pipelined
//
// Drives an XLEN=32 and an XLEN=64 instance with identical stimulus. Every
// accepted instruction pushes its expected result (from an arithmetic-shift
// reference model) into a queue; every output transfer pops and compares.
// -----------------------------------------------------------------------------
module tb_imm_gen_pipelined;

    logic        CLK = 1'b0;
    logic        RESET_N = 1'b0;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b0;
    logic [31:0] instruction = '0;
    logic [2:0]  imm_type = '0;
    logic [3:0]  in_tag = '0;

    logic        in_ready32, out_valid32, ill32;
    logic [31:0] imm32;
    logic [3:0]  tag32;
    logic        in_ready64, out_valid64, ill64;
    logic [63:0] imm64;
    logic [3:0]  tag64;

    always #5 CLK = ~CLK;

    imm_gen_pipelined #(.XLEN(32), .TAG_W(4)) dut32 (
        .CLK             (CLK),
        .RESET_N         (RESET_N),
        .IN_VALID        (in_valid),
        .IN_READY        (in_ready32),
        .INSTRUCTION     (instruction),
        .IMMEDIATE_TYPE  (imm_type),
        .IN_TAG          (in_tag),
        .OUT_VALID       (out_valid32),
        .OUT_READY       (out_ready),
        .IMMEDIATE_VALUE (imm32),
        .OUT_TAG         (tag32),
        .ILLEGAL_TYPE    (ill32)
    );

    imm_gen_pipelined #(.XLEN(64), .TAG_W(4)) dut64 (
        .CLK             (CLK),
        .RESET_N         (RESET_N),
        .IN_VALID        (in_valid),
        .IN_READY        (in_ready64),
        .INSTRUCTION     (instruction),
        .IMMEDIATE_TYPE  (imm_type),
        .IN_TAG          (in_tag),
        .OUT_VALID       (out_valid64),
        .OUT_READY       (out_ready),
        .IMMEDIATE_VALUE (imm64),
        .OUT_TAG         (tag64),
        .ILLEGAL_TYPE    (ill64)
    );

    typedef struct {
        logic [31:0] e32;
        logic [63:0] e64;
        logic [3:0]  tag;
        logic        ill;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    // Reference model built from signed arithmetic shifts of the whole word.
    function automatic logic [63:0] ref_imm(logic [31:0] ins, logic [2:0] t, bit x64);
        longint s;
        s = longint'($signed(ins));
        case (t)
            3'd0: return s >>> 20;
            3'd1: return ((s >>> 25) << 5) | longint'(ins[11:7]);
            3'd2: return ((s >>> 31) << 20) | (longint'(ins[19:12]) << 12)
                       | (longint'(ins[20]) << 11) | (longint'(ins[30:21]) << 1);
            3'd3: return (s >>> 12) << 12;
            3'd4: return ((s >>> 31) << 12) | (longint'(ins[7]) << 11)
                       | (longint'(ins[30:25]) << 5) | (longint'(ins[11:8]) << 1);
            3'd5: return x64 ? 64'(ins[25:20]) : 64'(ins[24:20]);
            3'd6: return 64'(ins[19:15]);
            default: return 64'd0;
        endcase
    endfunction

    task automatic check(string tag, logic [63:0] obs, logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    // Offer one instruction until accepted (bounded), then withdraw it.
    task automatic send(logic [31:0] ins, logic [2:0] t, logic [3:0] tg);
        bit done;
        done        = 1'b0;
        in_valid    = 1'b1;
        instruction = ins;
        imm_type    = t;
        in_tag      = tg;
        for (int i = 0; i < 100 && !done; i++) begin
            done = in_ready32;
            step();
        end
        in_valid = 1'b0;
        check("send_accepted", 64'(done), 64'd1);
    endtask

    task automatic drain();
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 10; i++) step();
        check("drain_empty", 64'(sb_q.size()), 64'd0);
    endtask

    // Scoreboard: observe both handshakes half a cycle before the edge on
    // which they complete.
    always @(negedge CLK) begin
        if (RESET_N) begin
            if (in_valid && in_ready32) begin
                exp_t e;
                logic [63:0] r32;
                r32   = ref_imm(instruction, imm_type, 1'b0);
                e.e32 = r32[31:0];
                e.e64 = ref_imm(instruction, imm_type, 1'b1);
                e.tag = in_tag;
                e.ill = (imm_type == 3'b111);
                sb_q.push_back(e);
            end
            if (out_valid32 && out_ready) begin
                n_checks++;
                assert (sb_q.size() != 0) else begin
                    n_fail++;
                    $error("FAIL sb_underflow: observed output tag %h expected no output", tag32);
                end
                if (sb_q.size() != 0) begin
                    exp_t e;
                    e = sb_q.pop_front();
                    check("sb_tag32", 64'(tag32), 64'(e.tag));
                    check("sb_imm32", 64'(imm32), 64'(e.e32));
                    check("sb_ill32", 64'(ill32), 64'(e.ill));
                    check("sb_valid64", 64'(out_valid64), 64'd1);
                    check("sb_tag64", 64'(tag64), 64'(e.tag));
                    check("sb_imm64", imm64, e.e64);
                    check("sb_ill64", 64'(ill64), 64'(e.ill));
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // ---------------- reset state ----------------
        repeat (3) step();
        check("rst_out_valid", 64'(out_valid32), 64'd0);
        check("rst_in_ready", 64'(in_ready32), 64'd0);
        check("rst_imm32", 64'(imm32), 64'd0);
        check("rst_imm64", imm64, 64'd0);
        check("rst_tag", 64'(tag32), 64'd0);
        check("rst_ill", 64'(ill32), 64'd0);
        RESET_N = 1'b1;
        #1;
        check("in_ready_before_edge", 64'(in_ready32), 64'd0);
        step();
        check("in_ready_after_edge", 64'(in_ready32), 64'd1);

        // ---------------- directed decode with 1-cycle latency ----------------
        out_ready = 1'b1;
        send(32'hFFF0_0093, 3'b000, 4'd3);
        check("lat_out_valid", 64'(out_valid32), 64'd1);
        check("i_imm32", 64'(imm32), 64'hFFFF_FFFF);
        check("i_imm64", imm64, 64'hFFFF_FFFF_FFFF_FFFF);
        check("i_ill", 64'(ill32), 64'd0);

        send(32'hFE00_0EE3, 3'b100, 4'd4);
        check("b_imm64", imm64, 64'hFFFF_FFFF_FFFF_FFFC);

        send(32'h03F0_1013, 3'b101, 4'd5);
        check("shamt_imm64", imm64, 64'h3F);
        check("shamt_imm32", 64'(imm32), 64'h1F);

        send(32'h03F0_1013, 3'b111, 4'd6);
        check("bad_imm32", 64'(imm32), 64'd0);
        check("bad_ill32", 64'(ill32), 64'd1);
        check("bad_ill64", 64'(ill64), 64'd1);

        // All formats with negative and positive words, scoreboard-checked.
        for (int t = 0; t < 8; t++) begin
            send(32'h8D3C_5A97, 3'(t), 4'(t));
            send(32'h7D3C_A5E9, 3'(t), 4'(t + 8));
        end
        drain();

        // ---------------- backpressure ----------------
        out_ready = 1'b0;
        send(32'h8123_4A23, 3'b001, 4'd1);
        check("bp_in_ready_one", 64'(in_ready32), 64'd1);
        check("bp_tag_first", 64'(tag32), 64'd1);
        send(32'h1234_5037, 3'b011, 4'd2);
        check("bp_in_ready_full", 64'(in_ready32), 64'd0);
        in_valid    = 1'b1;
        instruction = 32'hDEAD_BEEF;
        imm_type    = 3'b000;
        in_tag      = 4'd3;
        for (int i = 0; i < 3; i++) begin
            step();
            check("bp_hold_ready", 64'(in_ready32), 64'd0);
            check("bp_hold_tag", 64'(tag32), 64'd1);
            check("bp_hold_imm32", 64'(imm32), 64'(sb_q[0].e32));
            check("bp_hold_imm64", imm64, sb_q[0].e64);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        step();
        check("bp_release_tag2", 64'(tag32), 64'd2);
        step();
        check("bp_release_empty", 64'(out_valid32), 64'd0);
        check("bp_release_sb", 64'(sb_q.size()), 64'd0);

        // ---------------- random traffic ----------------
        for (int c = 0; c < 10000; c++) begin
            in_valid    = 1'($urandom_range(0, 1));
            out_ready   = ($urandom_range(0, 3) != 0);
            instruction = $urandom;
            imm_type    = 3'($urandom_range(0, 7));
            in_tag      = 4'(c);
            step();
        end
        drain();

        // ---------------- reset while FULL ----------------
        out_ready = 1'b0;
        send(32'h0010_0093, 3'b000, 4'd7);
        send(32'h0020_0093, 3'b001, 4'd8);
        check("rf_full", 64'(in_ready32), 64'd0);
        RESET_N = 1'b0;
        sb_q.delete();
        #1;
        check("rf_out_valid32", 64'(out_valid32), 64'd0);
        check("rf_out_valid64", 64'(out_valid64), 64'd0);
        check("rf_in_ready", 64'(in_ready32), 64'd0);
        check("rf_imm32", 64'(imm32), 64'd0);
        step();
        step();
        RESET_N = 1'b1;
        step();
        out_ready = 1'b1;
        send(32'h8000_006F, 3'b010, 4'd9);
        check("rf_first_valid", 64'(out_valid32), 64'd1);
        check("rf_first_tag", 64'(tag32), 64'd9);
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_imm_gen_pipelined
